ifmap_skew_feeder: RTL

//  Upstream stage of the systolic MAC array. Accepts one column vector of ifmaps
//  per handshake (one lane per array row) and skews it diagonally: row r sees its

---
 rtl/systolic_pkg.sv | 19 +
 rtl/skew_delay_line.sv | 35 +++
 rtl/ifmap_skew_feeder.sv | 106 ++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared constants and types for the systolic array front-end.
// The ifmap_skew_feeder optional perf counter is enabled by IFMAP_SKEW_PERF_EN.
package systolic_pkg;

  localparam int DEFAULT_ARRAY_HEIGHT = 4;
  localparam int DEFAULT_IFMAP_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } feeder_state_t;

  // Drain counter must hold ARRAY_HEIGHT-1; never narrower than one bit.
  function automatic int drain_cnt_width(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Per-row shift register with a common advance enable; output is the last stage.
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg[0] <= '0;
    end else if (advance) begin
      stage_reg[0] <= din;
    end
  end

  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_reg[gi] <= '0;
      end else if (advance) begin
        stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/ifmap_skew_feeder.sv
// Diagonal skew of ifmap column vectors into the systolic array, with zero-padded drain.
// Define IFMAP_SKEW_PERF_EN to add the bubble_count performance port.
module ifmap_skew_feeder
  import systolic_pkg::*;
#(
  parameter int ARRAY_HEIGHT = DEFAULT_ARRAY_HEIGHT,
  parameter int IFMAP_WIDTH  = DEFAULT_IFMAP_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              ifmap_valid,
  output logic                              ifmap_ready,
  input  logic [ARRAY_HEIGHT*IFMAP_WIDTH-1:0] ifmap_data,
  input  logic                              ifmap_last,
  output logic [ARRAY_HEIGHT*IFMAP_WIDTH-1:0] array_ifmap,
  output logic                              array_enable,
`ifdef IFMAP_SKEW_PERF_EN
  output logic                              busy,
  output logic [31:0]                       bubble_count
`else
  output logic                              busy
`endif
);

  localparam int CNT_W = drain_cnt_width(ARRAY_HEIGHT);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(ARRAY_HEIGHT - 1);

  feeder_state_t    state_reg;
  logic [CNT_W-1:0] drain_cnt_reg;
  logic             enable_reg;
  logic             draining;
  logic             handshake;
  logic             advance;

  assign draining     = (state_reg == DRAIN);
  assign ifmap_ready  = !draining;
  assign handshake    = ifmap_valid && ifmap_ready;
  assign advance      = handshake || draining;
  assign busy         = (state_reg != IDLE);
  assign array_enable = enable_reg;

  // Drain advances push zeros so the tail of the last vector walks out cleanly.
  for (genvar gi = 0; gi < ARRAY_HEIGHT; gi++) begin : g_row
    logic [IFMAP_WIDTH-1:0] lane_in;
    assign lane_in = draining ? '0 : ifmap_data[gi*IFMAP_WIDTH +: IFMAP_WIDTH];

    skew_delay_line #(
      .DEPTH (gi + 1),
      .WIDTH (IFMAP_WIDTH)
    ) u_row (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (advance),
      .din     (lane_in),
      .dout    (array_ifmap[gi*IFMAP_WIDTH +: IFMAP_WIDTH])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      drain_cnt_reg <= '0;
      enable_reg    <= 1'b0;
    end else begin
      enable_reg <= advance;
      case (state_reg)
        IDLE, STREAM: begin
          if (handshake) begin
            if (!ifmap_last) begin
              state_reg <= STREAM;
            end else if (ARRAY_HEIGHT > 1) begin
              state_reg     <= DRAIN;
              drain_cnt_reg <= DRAIN_LOAD;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_reg <= CNT_W'(1)) begin
            drain_cnt_reg <= '0;
            state_reg     <= IDLE;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef IFMAP_SKEW_PERF_EN
  logic [31:0] bubble_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_reg <= '0;
    end else if ((state_reg == STREAM) && !ifmap_valid && (bubble_cnt_reg != '1)) begin
      bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
    end
  end

  assign bubble_count = bubble_cnt_reg;
`endif

endmodule
